// File: rtl/tournament_selection.sv
// Parent selection for the GA datapath: two binary tournaments over the population
// memory, indices drawn from a free-running Galois LFSR, result offered on valid/ready.
module tournament_selection #(
    parameter int          CHROM_WIDTH = 8,
    parameter int          FIT_WIDTH   = 8,
    parameter int          POP_SIZE    = 16,
    parameter int          ADDR_WIDTH  = $clog2(POP_SIZE),
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   mem_rd_en,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [CHROM_WIDTH-1:0] mem_chrom,
    input  logic [FIT_WIDTH-1:0]   mem_fit,
    output logic                   pair_valid,
    input  logic                   pair_ready,
    output logic [CHROM_WIDTH-1:0] parent1,
    output logic [CHROM_WIDTH-1:0] parent2
);

    localparam logic [15:0] SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam logic [ADDR_WIDTH-1:0] IDX_MASK = ADDR_WIDTH'(POP_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH_A,
        FETCH_B,
        COMPARE,
        DONE
    } state_t;

    state_t                 state_reg;
    logic [15:0]            lfsr_reg;
    logic [15:0]            lfsr_next;
    logic                   tourn_reg;
    logic [CHROM_WIDTH-1:0] chrom_a_reg;
    logic [FIT_WIDTH-1:0]   fit_a_reg;
    logic [ADDR_WIDTH-1:0]  rnd_next;
    logic [CHROM_WIDTH-1:0] winner;

    assign lfsr_next = lfsr_reg[0] ? ((lfsr_reg >> 1) ^ LFSR_MASK) : (lfsr_reg >> 1);

    // mem_addr is registered, so it is loaded with the LFSR value that will be
    // current during the issuing FETCH cycle.
    assign rnd_next = lfsr_next[ADDR_WIDTH-1:0] & IDX_MASK;

    // Ties keep A.
    assign winner = (mem_fit > fit_a_reg) ? mem_chrom : chrom_a_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            lfsr_reg    <= SEED_EFF;
            tourn_reg   <= 1'b0;
            chrom_a_reg <= '0;
            fit_a_reg   <= '0;
            busy        <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_addr    <= '0;
            pair_valid  <= 1'b0;
            parent1     <= '0;
            parent2     <= '0;
        end else begin
            lfsr_reg <= lfsr_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= FETCH_A;
                        tourn_reg <= 1'b0;
                        busy      <= 1'b1;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= rnd_next;
                    end
                end
                FETCH_A: begin
                    state_reg <= FETCH_B;
                    mem_rd_en <= 1'b1;
                    mem_addr  <= rnd_next;
                end
                FETCH_B: begin
                    chrom_a_reg <= mem_chrom;
                    fit_a_reg   <= mem_fit;
                    state_reg   <= COMPARE;
                    mem_rd_en   <= 1'b0;
                end
                COMPARE: begin
                    if (!tourn_reg) begin
                        parent1   <= winner;
                        tourn_reg <= 1'b1;
                        state_reg <= FETCH_A;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= rnd_next;
                    end else begin
                        parent2    <= winner;
                        state_reg  <= DONE;
                        pair_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (pair_ready) begin
                        state_reg  <= IDLE;
                        pair_valid <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    busy       <= 1'b0;
                    mem_rd_en  <= 1'b0;
                    pair_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
